// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch -- instruction fetch stage with a small prefetch queue.
//
// The PC walks sequentially through instruction memory (combinational read),
// pushing {pc, instr} pairs into a circular FIFO that decode drains through a
// valid/ready handshake. A redirect flushes the queue and reloads the PC.
//
// Optional feature macro: IF_MISALIGN_CHK_EN
//   defined   : a redirect to a non word-aligned address loads the PC as-is,
//               raises a sticky misalign_err and halts fetching until reset
//               or an aligned redirect.
//   undefined : the low two redirect address bits are forced to zero and
//               misalign_err is tied low.
// ============================================================================
module if_prefetch #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       fetch_en,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_addr,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_instr,
    output logic [XLEN-1:0]            id_pc,
    output logic                       if_flush,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic                       misalign_err
);

    localparam int              AW        = $clog2(DEPTH);
    localparam int              CW        = AW + 1;
    localparam logic [CW-1:0]   DEPTH_CNT = CW'(DEPTH);

    // Architectural fetch state
    logic [XLEN-1:0] pc_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW-1:0]   wr_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Queue storage; the head is read combinationally so a freshly pushed
    // entry is visible to decode one cycle after it was fetched.
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic            push;
    logic            pop;
    logic            halted;
    logic [XLEN-1:0] redirect_pc;

`ifdef IF_MISALIGN_CHK_EN
    logic halted_reg;

    // Sticky halt: set by a misaligned redirect, cleared by an aligned one
    always_ff @(posedge clk) begin
        if (reset) begin
            halted_reg <= 1'b0;
        end else if (redirect) begin
            halted_reg <= (redirect_addr[1:0] != 2'b00);
        end
    end

    assign halted       = halted_reg;
    assign misalign_err = halted_reg;
    assign redirect_pc  = redirect_addr;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
    assign redirect_pc  = redirect_addr & ~XLEN'(3);
`endif

    // Handshake decode: redirect suppresses both ends of the queue
    always_comb begin
        id_valid = (count_reg != '0) && !redirect;
        pop      = id_valid && id_ready;
        push     = fetch_en && !redirect && !halted &&
                   ((count_reg < DEPTH_CNT) || pop);
    end

    assign imem_addr = pc_reg;
    assign if_flush  = redirect;
    assign q_count   = count_reg;
    assign id_pc     = pc_mem[rd_ptr_reg];
    assign id_instr  = instr_mem[rd_ptr_reg];

    // Queue entry write at the tail on every push
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            pc_mem[wr_ptr_reg]    <= pc_reg;
            instr_mem[wr_ptr_reg] <= imem_rdata;
        end
    end

    // PC, pointers and occupancy: reset beats redirect beats push/pop
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (redirect) begin
            pc_reg     <= redirect_pc;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                pc_reg     <= pc_reg + XLEN'(4);
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter XLEN, default 32, width of PC, redirect address and instruction word.
REQ-002 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 fetch_en  input  1  fetch permit; low freezes PC and pushes, pops still allowed.
REQ-007 redirect  input  1  branch/jump taken; flush queue and load redirect_addr.
REQ-008 redirect_addr  input  XLEN  new fetch address.
REQ-009 imem_addr  output  XLEN  byte address to instruction memory; equals PC.
REQ-010 imem_rdata  input  XLEN  instruction at imem_addr, combinational (same cycle).
REQ-011 id_valid  output  1  queue head holds a valid instruction.
REQ-012 id_ready  input  1  decode accepts head this cycle.
REQ-013 id_instr  output  XLEN  head instruction.
REQ-014 id_pc  output  XLEN  PC of head instruction.
REQ-015 if_flush  output  1  combinational copy of redirect, for downstream flush.
REQ-016 q_count  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-017 misalign_err  output  1  misaligned redirect flag (see Configuration).

Function
REQ-018 Queue SHALL be circular FIFO of DEPTH entries {pc, instr}, read/write pointers wrap modulo DEPTH.
REQ-019 pop SHALL equal id_valid && id_ready && !redirect.
REQ-020 push SHALL equal fetch_en && !redirect && !halted && (q_count < DEPTH || pop).
REQ-021 On push, entry {PC, imem_rdata} SHALL be written at tail and PC SHALL advance by 4, modulo 2^XLEN.
REQ-022 Simultaneous push and pop SHALL leave q_count unchanged, including when full.
REQ-023 id_valid SHALL be (q_count != 0) && !redirect; id_instr/id_pc undefined-but-stable when id_valid low.
REQ-024 Fetch-to-id_valid latency SHALL be 1 cycle: instruction pushed at edge N visible at head after N if queue was empty.
REQ-025 Priority per edge: reset > redirect > push/pop.
REQ-026 On redirect (no reset): queue emptied (q_count=0, pointers equal), PC <= redirect_addr, no push, no pop that cycle.
REQ-027 Full queue with no pop: PC held, no push, imem_addr stable.
REQ-028 Empty queue with id_ready high: no pop, q_count stays 0.
REQ-029 fetch_en low: PC and tail held; pops continue, draining queue.
REQ-030 Sequential order SHALL be preserved: consecutive id_pc values differ by 4 between redirects.

Reset
REQ-031 On reset edge: PC=RESET_PC, q_count=0, pointers 0, misalign_err=0, halted=0; id_valid=0 next cycle.
REQ-032 Reset mid-operation SHALL discard all queued entries and override same-cycle redirect.

Configuration
REQ-033 Macro IF_MISALIGN_CHK_EN defined: redirect with redirect_addr[1:0]!=0 SHALL load PC, set misalign_err and halted (sticky); pushes stop; cleared only by reset or aligned redirect.
REQ-034 Macro IF_MISALIGN_CHK_EN undefined: redirect_addr[1:0] SHALL be forced to 0 when loaded into PC, misalign_err tied 0, halted always 0.

Verification
REQ-035 Reset, fetch_en=1, id_ready=1, imem_rdata=addr-derived -> id_pc 0,4,8,... one per cycle from cycle 2, q_count steady at 1.
REQ-036 id_ready=0 for 10 cycles, DEPTH=4 -> q_count reaches 4, PC frozen at 0x10; id_ready=1 -> 0x0,0x4,0x8,0xC then 0x10 with no gap.
REQ-037 Queue holds 3 entries, redirect=1 with redirect_addr=0x100, id_ready=1 -> that cycle id_valid=0, if_flush=1; next cycle q_count=0, PC=0x100; following id_pc=0x100.
REQ-038 reset and redirect (0x200) same edge -> PC=RESET_PC, q_count=0.
REQ-039 With IF_MISALIGN_CHK_EN, redirect to 0x102 -> misalign_err=1, q_count drains to 0, no pushes; redirect to 0x300 -> misalign_err=0, fetch resumes at 0x300; without macro, same stimulus -> PC=0x100, misalign_err=0.
REQ-040 PC=0xFFFFFFFC (XLEN=32), push -> next PC=0x00000000, no error.
